// File: rtl/gray_decoder_checker_if.sv
// Gray sample bus and decoder status outputs.
// The producer drives the sample; the decoder drives conversion, step and lock status.
interface gray_decoder_checker_if #(
  parameter int WIDTH = 5,
  parameter int ERR_W = 8
);
  logic [WIDTH-1:0] gray_in;
  logic             gray_valid;
  logic [WIDTH-1:0] bin_out;
  logic             bin_valid;
  logic             step_ok;
  logic             step_err;
  logic             dir_up;
  logic             locked;
  logic [ERR_W-1:0] err_count;

  modport master (
    output gray_in, gray_valid,
    input  bin_out, bin_valid, step_ok, step_err,
    input  dir_up, locked, err_count
  );

  modport slave (
    input  gray_in, gray_valid,
    output bin_out, bin_valid, step_ok, step_err,
    output dir_up, locked, err_count
  );
endinterface

// File: rtl/gray_decoder_checker.sv
// Gray-to-binary receiver with single-bit step check,
// direction report, lock FSM and saturating error counter.
module gray_decoder_checker #(
  parameter int WIDTH  = 5,
  parameter int LOCK_N = 4,
  parameter int ERR_W  = 8
) (
  input logic clk,
  input logic rst,
  gray_decoder_checker_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACQ,
    S_LOCK
  } state_t;

  function automatic logic [WIDTH-1:0] g2b(
    input logic [WIDTH-1:0] g
  );
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_prev_gray;
  logic [WIDTH-1:0] r_bin;
  logic             r_bin_valid;
  logic             r_step_ok;
  logic             r_step_err;
  logic             r_dir_up;
  logic [3:0]       r_good;
  logic [ERR_W-1:0] r_err_cnt;

  logic [WIDTH-1:0] w_bin;
  logic [WIDTH-1:0] w_prev_bin;
  logic [WIDTH-1:0] w_inc;
  logic [WIDTH-1:0] w_diff;
  logic             w_one;
  logic             w_multi;
  logic             w_up;
  logic [3:0]       w_good_inc;
  logic [3:0]       w_good_nx;
  logic             w_ok_nx;
  logic             w_err_nx;
  logic             w_dir_nx;

  assign w_bin      = g2b(bus.gray_in);
  assign w_prev_bin = g2b(r_prev_gray);
  assign w_inc      = w_prev_bin + WIDTH'(1);
  assign w_diff     = bus.gray_in ^ r_prev_gray;
  assign w_one      = $onehot(w_diff);
  assign w_multi    = (w_diff != '0) && !w_one;
  assign w_up       = (w_bin == w_inc);
  assign w_good_inc = r_good + 4'd1;

  always_comb begin
    w_next    = r_state;
    w_good_nx = r_good;
    w_ok_nx   = 1'b0;
    w_err_nx  = 1'b0;
    w_dir_nx  = r_dir_up;
    if (bus.gray_valid) begin
      unique case (r_state)
        S_IDLE: w_next = S_ACQ;
        S_ACQ: begin
          if (w_one) begin
            w_ok_nx   = 1'b1;
            w_dir_nx  = w_up;
            w_good_nx = w_good_inc;
            if (w_good_inc == 4'(LOCK_N))
              w_next = S_LOCK;
          end else if (w_multi) begin
            w_err_nx  = 1'b1;
            w_good_nx = '0;
          end
        end
        S_LOCK: begin
          if (w_one) begin
            w_ok_nx  = 1'b1;
            w_dir_nx = w_up;
          end else if (w_multi) begin
            w_err_nx  = 1'b1;
            w_good_nx = '0;
            w_next    = S_ACQ;
          end
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_prev_gray <= '0;
      r_bin       <= '0;
      r_bin_valid <= 1'b0;
      r_step_ok   <= 1'b0;
      r_step_err  <= 1'b0;
      r_dir_up    <= 1'b0;
      r_good      <= '0;
      r_err_cnt   <= '0;
    end else begin
      r_state     <= w_next;
      r_bin_valid <= bus.gray_valid;
      r_step_ok   <= w_ok_nx;
      r_step_err  <= w_err_nx;
      r_dir_up    <= w_dir_nx;
      r_good      <= w_good_nx;
      if (bus.gray_valid) begin
        r_prev_gray <= bus.gray_in;
        r_bin       <= w_bin;
      end
      // saturate rather than wrap so a burst of errors stays visible
      if (w_err_nx && (r_err_cnt != '1))
        r_err_cnt <= r_err_cnt + ERR_W'(1);
    end
  end

  assign bus.bin_out   = r_bin;
  assign bus.bin_valid = r_bin_valid;
  assign bus.step_ok   = r_step_ok;
  assign bus.step_err  = r_step_err;
  assign bus.dir_up    = r_dir_up;
  assign bus.locked    = (r_state == S_LOCK);
  assign bus.err_count = r_err_cnt;

endmodule

// File: tb/tb_gray_decoder_checker.sv
// Bench: directed plan plus random walk, checked against a
// sequence-index reference model on two error-counter widths.
module tb_gray_decoder_checker;

  localparam int W = 5;
  localparam int LOCK_N = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  gray_decoder_checker_if #(.WIDTH(W), .ERR_W(8)) if_a ();
  gray_decoder_checker_if #(.WIDTH(W), .ERR_W(2)) if_b ();

  gray_decoder_checker #(.WIDTH(W), .LOCK_N(LOCK_N), .ERR_W(8)) u_a (
    .clk(clk), .rst(rst), .bus(if_a)
  );
  gray_decoder_checker #(.WIDTH(W), .LOCK_N(LOCK_N), .ERR_W(2)) u_b (
    .clk(clk), .rst(rst), .bus(if_b)
  );

  int n_vec = 0;
  int n_cmp = 0;
  int n_bad = 0;

  int inv [32];
  int m_state, m_prev, m_good, m_errs;
  int m_bin, m_dir, m_bv, m_ok, m_se;

  function automatic int gray_of(input int b);
    return b ^ (b >> 1);
  endfunction

  function automatic int pop(input int x);
    int c = 0;
    for (int i = 0; i < W; i++) c += (x >> i) & 1;
    return c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model(input bit r, input bit v, input int g);
    m_bv = 0; m_ok = 0; m_se = 0;
    if (r) begin
      m_state = 0; m_prev = 0; m_good = 0; m_errs = 0;
      m_bin = 0; m_dir = 0;
    end else if (v) begin
      m_bv = 1;
      m_bin = inv[g];
      if (m_state != 0) begin
        if (pop(g ^ m_prev) == 1) begin
          m_ok = 1;
          m_dir = (inv[g] == (inv[m_prev] + 1) % 32) ? 1 : 0;
          if (m_state == 1) begin
            m_good++;
            if (m_good == LOCK_N) m_state = 2;
          end
        end else if (pop(g ^ m_prev) >= 2) begin
          m_se = 1;
          m_errs++;
          m_good = 0;
          m_state = 1;
        end
      end else begin
        m_state = 1;
      end
      m_prev = g;
    end
  endtask

  task automatic step(input bit r, input bit v, input int g);
    logic [W-1:0] gv;
    gv = g[W-1:0];
    rst = r;
    if_a.gray_valid = v; if_a.gray_in = gv;
    if_b.gray_valid = v; if_b.gray_in = gv;
    @(posedge clk);
    #1;
    n_vec++;
    model(r, v, g);
    chk("bin_out", 32'(if_a.bin_out), m_bin);
    chk("bin_valid", 32'(if_a.bin_valid), m_bv);
    chk("step_ok", 32'(if_a.step_ok), m_ok);
    chk("step_err", 32'(if_a.step_err), m_se);
    chk("dir_up", 32'(if_a.dir_up), m_dir);
    chk("locked", 32'(if_a.locked), (m_state == 2) ? 1 : 0);
    chk("err_a", 32'(if_a.err_count), (m_errs > 255) ? 255 : m_errs);
    chk("err_b", 32'(if_b.err_count), (m_errs > 3) ? 3 : m_errs);
    chk("bin_b", 32'(if_b.bin_out), m_bin);
    chk("lock_b", 32'(if_b.locked), 32'(if_a.locked));
  endtask

  initial begin
    int cur, k;
    for (int i = 0; i < 32; i++) inv[gray_of(i)] = i;
    m_state = 0; m_prev = 0; m_good = 0; m_errs = 0;
    m_bin = 0; m_dir = 0; m_bv = 0; m_ok = 0; m_se = 0;
    if_a.gray_valid = 0; if_a.gray_in = '0;
    if_b.gray_valid = 0; if_b.gray_in = '0;

    step(1, 0, 0);
    step(1, 1, 5'b10101);
    chk("rst_lock", 32'(if_a.locked), 0);

    // plan 1: lock on the fourth upward step
    step(0, 1, 5'b00000);
    step(0, 1, 5'b00001);
    step(0, 1, 5'b00011);
    step(0, 1, 5'b00010);
    chk("t1_unlocked", 32'(if_a.locked), 0);
    step(0, 1, 5'b00110);
    chk("t1_locked", 32'(if_a.locked), 1);
    chk("t1_bin", 32'(if_a.bin_out), 4);

    // plan 2: wrap 31 -> 0 -> 31
    for (int b = 5; b < 32; b++) step(0, 1, gray_of(b));
    step(0, 1, 5'b00000);
    chk("t2_dir_up", 32'(if_a.dir_up), 1);
    step(0, 1, 5'b10000);
    chk("t2_dir_dn", 32'(if_a.dir_up), 0);
    chk("t2_bin", 32'(if_a.bin_out), 31);
    chk("t2_lock", 32'(if_a.locked), 1);

    // plan 3: double-bit error while locked, then relock
    step(1, 0, 0);
    for (int b = 30; b < 35; b++) step(0, 1, gray_of(b % 32));
    chk("t3_pre_lock", 32'(if_a.locked), 1);
    step(0, 1, 5'b00101);
    chk("t3_err", 32'(if_a.step_err), 1);
    chk("t3_bin", 32'(if_a.bin_out), 6);
    chk("t3_cnt", 32'(if_a.err_count), 1);
    for (int b = 7; b <= 10; b++) step(0, 1, gray_of(b));
    chk("t3_relock", 32'(if_a.locked), 1);

    // plan 4: repeats while locked
    for (int b = 9; b >= 4; b--) step(0, 1, gray_of(b));
    step(0, 1, 5'b00110);
    step(0, 1, 5'b00110);
    chk("t4_lock", 32'(if_a.locked), 1);
    chk("t4_cnt", 32'(if_a.err_count), 1);

    // plan 5: saturation on the narrow counter
    step(1, 0, 0);
    step(0, 1, 5'b00000);
    for (int i = 0; i < 5; i++)
      step(0, 1, (i % 2 == 0) ? 5'b00011 : 5'b00000);
    chk("t5_sat", 32'(if_b.err_count), 3);
    chk("t5_wide", 32'(if_a.err_count), 5);
    chk("t5_lock", 32'(if_b.locked), 0);

    // plan 6: reset mid-acquisition with a valid sample
    step(1, 0, 0);
    step(0, 1, 5'b00000);
    step(0, 1, 5'b00001);
    step(0, 1, 5'b00011);
    step(1, 1, 5'b00010);
    chk("t6_bin", 32'(if_a.bin_out), 0);
    chk("t6_bv", 32'(if_a.bin_valid), 0);
    step(0, 1, 5'b00111);
    chk("t6_nostep", 32'(if_a.step_ok), 0);
    chk("t6_bin5", 32'(if_a.bin_out), 5);

    // random walk
    cur = 5;
    for (int n = 0; n < 400; n++) begin
      k = $urandom_range(0, 99);
      if (k < 3) begin
        step(1, $urandom_range(0, 1), gray_of(cur));
      end else if (k < 15) begin
        step(0, 0, $urandom_range(0, 31));
      end else if (k < 25) begin
        step(0, 1, gray_of(cur));
      end else if (k < 35) begin
        cur = $urandom_range(0, 31);
        step(0, 1, gray_of(cur));
      end else begin
        cur = ($urandom_range(0, 1) != 0) ? (cur + 1) % 32 : (cur + 31) % 32;
        step(0, 1, gray_of(cur));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
